regfile_core: RTL and testbench

REGFILE_CORE -- requirements
Module: regfile_core

---
 rtl/regfile_core.sv | 53 +++++
 tb/tb_regfile_core.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
//  regfile_core : 4-entry register file, R0 hardwired to zero, 2 async reads
//  Revision     : 1.0
// ============================================================================
module regfile_core #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        rs,
  input  logic [1:0]        rt,
  input  logic [1:0]        rd,
  input  logic              we,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] temp
);

  logic [3:0]             w_dec;
  logic [3:1][DATA_W-1:0] r_regs;
  logic [3:0][DATA_W-1:0] w_bank;

  always_comb begin
    w_dec     = '0;
    w_dec[rd] = 1'b1;
  end

  // Only R1..R3 have storage; a write to rd=0 simply finds no register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_regs <= '0;
    end else begin
      for (int k = 1; k < 4; k++) begin
        if (we && w_dec[k]) begin
          r_regs[k] <= writedata;
        end
      end
    end
  end

  always_comb begin
    w_bank      = '0;
    w_bank[3:1] = r_regs;
  end

  assign A    = w_bank[rs];
  assign temp = w_bank[rt];

  a_dec_onehot : assert property (@(posedge clock) disable iff (!resetn) $onehot(w_dec));

endmodule
`default_nettype wire

// File: tb/tb_regfile_core.sv
`default_nettype none
// ============================================================================
//  tb_regfile_core : directed scoreboard bench for regfile_core
//  Revision        : 1.0
// ============================================================================
module tb_regfile_core;

  logic       clock;
  logic       resetn;
  logic [1:0] rs, rt, rd;
  logic       we;
  logic [3:0] writedata;
  logic [3:0] A, temp;

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] t;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m [4];
  int         vectors = 0;
  int         miscompares = 0;

  regfile_core #(.DATA_W(4)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .we       (we),
    .writedata(writedata),
    .A        (A),
    .temp     (temp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected values come from the bench model m[], pushed when the read is driven.
  task automatic check(input string tag, input logic [1:0] s, input logic [1:0] t);
    exp_t e;
    rs = s;
    rt = t;
    q.push_back('{tag, m[s], m[t]});
    #1;
    e = q.pop_front();
    vectors++;
    assert (A === e.a) else begin
      miscompares++;
      $error("FAIL %s A: got %h expected %h", e.tag, A, e.a);
    end
    vectors++;
    assert (temp === e.t) else begin
      miscompares++;
      $error("FAIL %s temp: got %h expected %h", e.tag, temp, e.t);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic en);
    @(negedge clock);
    rd = a;
    writedata = d;
    we = en;
    @(posedge clock);
    #1;
    if (en && resetn && a != 2'd0) m[a] = d;
    we = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 4'h0;
  endtask

  initial begin
    model_reset();
    resetn = 1'b0; rs = 2'd1; rt = 2'd3; rd = 2'd0; we = 1'b0; writedata = 4'h0;
    check("reset_noedge", 2'd1, 2'd3);

    // Writes are blocked while reset is held.
    do_write(2'd1, 4'hF, 1'b1);
    check("reset_wr_blocked", 2'd1, 2'd1);

    @(negedge clock);
    resetn = 1'b1;
    do_write(2'd1, 4'hA, 1'b1);
    do_write(2'd2, 4'h5, 1'b1);
    do_write(2'd3, 4'hF, 1'b1);
    check("rd_r1_r3", 2'd1, 2'd3);
    check("rd_r2_r2", 2'd2, 2'd2);
    check("rd_r0_r1", 2'd0, 2'd1);

    do_write(2'd0, 4'hF, 1'b1);
    check("r0_zero", 2'd0, 2'd0);
    check("r0_r1_r2_hold", 2'd1, 2'd2);
    check("r0_r3_hold", 2'd3, 2'd3);

    do_write(2'd2, 4'h3, 1'b0);
    check("we0_hold", 2'd2, 2'd1);

    // No bypass: old value before the edge, new value after it.
    @(negedge clock);
    rs = 2'd1; rt = 2'd1; rd = 2'd1; we = 1'b1; writedata = 4'h6;
    check("nobypass_before", 2'd1, 2'd1);
    @(posedge clock);
    #1;
    m[1] = 4'h6;
    we = 1'b0;
    check("nobypass_after", 2'd1, 2'd3);

    // Input glitches between edges must not change state.
    @(negedge clock);
    we = 1'b1; rd = 2'd3; writedata = 4'h1;
    #1 rd = 2'd2; writedata = 4'h9;
    #1 we = 1'b0;
    @(posedge clock);
    #1;
    check("glitch_r3_r2", 2'd3, 2'd2);

    // Async reset between edges.
    @(negedge clock);
    #1 resetn = 1'b0;
    model_reset();
    check("async_rst_r1_r2", 2'd1, 2'd2);
    check("async_rst_r3_r0", 2'd3, 2'd0);
    #1 resetn = 1'b1;
    do_write(2'd2, 4'h9, 1'b1);
    check("post_rst_wr", 2'd2, 2'd1);

    // Reset right after a write edge discards the written value.
    do_write(2'd3, 4'h7, 1'b1);
    check("pre_discard", 2'd3, 2'd2);
    #1 resetn = 1'b0;
    model_reset();
    check("discard_r3", 2'd3, 2'd2);
    #1 resetn = 1'b1;
    do_write(2'd3, 4'hC, 1'b1);
    check("rewrite_r3", 2'd3, 2'd3);

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
